// File: rtl/stoch_patch_sched_pkg.sv
// rtl/stoch_patch_sched_pkg.sv - shared types and sizing helpers for the stochastic patch scheduler
//
// Contents:
//   state_t     : sweep FSM states (IDLE, RUN, DONE)
//   out_dim     : number of window positions along one axis (floor division)
//   clog2_safe  : $clog2 that never returns less than 1, for counter/port widths
package stoch_patch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int out_dim(input int size, input int patch, input int stride, input int pad);
        return (size + 2 * pad - patch) / stride + 1;
    endfunction

    // A single-position axis still needs a 1-bit counter/port.
    function automatic int clog2_safe(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/stoch_signed_dyn_patch.sv
// rtl/stoch_signed_dyn_patch.sv - combinational patch selector with runtime signed origin
//
// Ports:
//   base_h, base_w   in   signed window origin (may be negative under padding)
//   in_p, in_m       in   [HEIGHT][WIDTH][CHANNELS] plus/minus stream bits
//   patch_p, patch_m out  [CHANNELS][PATCH_H][PATCH_W] selected bits, DEFAULT where
//                         the element falls outside the feature map
module stoch_signed_dyn_patch
    import stoch_patch_sched_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter int   HEIGHT   = 32,
    parameter int   CHANNELS = 3,
    parameter int   PATCH_W  = 3,
    parameter int   PATCH_H  = 3,
    parameter int   BW       = 8,
    parameter logic DEFAULT  = 1'b0
) (
    input  logic signed [BW-1:0]                             base_h,
    input  logic signed [BW-1:0]                             base_w,
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]       in_p,
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]       in_m,
    output logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0]    patch_p,
    output logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0]    patch_m
);

    localparam int HW = clog2_safe(HEIGHT);
    localparam int WW = clog2_safe(WIDTH);
    localparam logic signed [BW-1:0] H_LIM = BW'(HEIGHT);
    localparam logic signed [BW-1:0] W_LIM = BW'(WIDTH);

    // Bounds and index are resolved once per patch row and once per patch column,
    // then shared by every channel.
    logic [PATCH_H-1:0]          row_ok;
    logic [PATCH_H-1:0][HW-1:0]  row_idx;
    logic [PATCH_W-1:0]          col_ok;
    logic [PATCH_W-1:0][WW-1:0]  col_idx;

    for (genvar r = 0; r < PATCH_H; r++) begin : g_row
        logic signed [BW-1:0] h;
        assign h          = base_h + BW'(r);
        assign row_ok[r]  = !h[BW-1] && (h < H_LIM);
        assign row_idx[r] = h[HW-1:0];
    end

    for (genvar k = 0; k < PATCH_W; k++) begin : g_col
        logic signed [BW-1:0] w;
        assign w          = base_w + BW'(k);
        assign col_ok[k]  = !w[BW-1] && (w < W_LIM);
        assign col_idx[k] = w[WW-1:0];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar r = 0; r < PATCH_H; r++) begin : g_r
            for (genvar k = 0; k < PATCH_W; k++) begin : g_k
                assign patch_p[c][r][k] = (row_ok[r] && col_ok[k]) ? in_p[row_idx[r]][col_idx[k]][c] : DEFAULT;
                assign patch_m[c][r][k] = (row_ok[r] && col_ok[k]) ? in_m[row_idx[r]][col_idx[k]][c] : DEFAULT;
            end
        end
    end

endmodule

// File: rtl/stoch_patch_scheduler.sv
// rtl/stoch_patch_scheduler.sv - time-multiplexed sliding-window sweep over a p/m bitstream map
//
// Optional build macro: STOCH_PATCH_SCHED_ABORT_EN (adds the abort input).
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   start              pulse, begins a sweep when idle
//   abort              (macro only) drop the sweep back to idle, no done pulse
//   in_p, in_m         feature-map bits of the current stochastic beat
//   patch_p, patch_m   selected window patch, combinational from in_p/in_m
//   patch_valid/ready  beat handshake toward the MAC array
//   out_row, out_col   current window position
//   first_bit/last_bit beat is bit 0 / bit BITS-1 of the window
//   in_advance         upstream may step to its next bit
//   busy, done         sweep in progress / one-cycle completion pulse
module stoch_patch_scheduler
    import stoch_patch_sched_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter int   HEIGHT   = 32,
    parameter int   CHANNELS = 3,
    parameter int   PATCH_W  = 3,
    parameter int   PATCH_H  = 3,
    parameter int   STRIDE   = 1,
    parameter int   PAD      = 1,
    parameter int   BITS     = 256,
    parameter logic DEFAULT  = 1'b0
) (
    input  logic                                                    CLK,
    input  logic                                                    nRST,
    input  logic                                                    start,
`ifdef STOCH_PATCH_SCHED_ABORT_EN
    input  logic                                                    abort,
`endif
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]              in_p,
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]              in_m,
    output logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0]           patch_p,
    output logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0]           patch_m,
    output logic                                                    patch_valid,
    input  logic                                                    patch_ready,
    output logic [clog2_safe(out_dim(HEIGHT, PATCH_H, STRIDE, PAD))-1:0] out_row,
    output logic [clog2_safe(out_dim(WIDTH, PATCH_W, STRIDE, PAD))-1:0]  out_col,
    output logic                                                    first_bit,
    output logic                                                    last_bit,
    output logic                                                    in_advance,
    output logic                                                    busy,
    output logic                                                    done
);

    localparam int OUT_W = out_dim(WIDTH, PATCH_W, STRIDE, PAD);
    localparam int OUT_H = out_dim(HEIGHT, PATCH_H, STRIDE, PAD);
    localparam int RW    = clog2_safe(OUT_H);
    localparam int CW    = clog2_safe(OUT_W);
    localparam int BCW   = clog2_safe(BITS);
    localparam int MAXD  = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
    localparam int BW    = clog2_safe(MAXD + PAD) + 2;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(OUT_H - 1);

    state_t          state_q, state_d;
    logic [BCW-1:0]  bit_q, bit_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic signed [BW-1:0] base_h, base_w;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            bit_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // bit -> col -> row odometer, stepped only on an accepted beat.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    bit_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
`ifdef STOCH_PATCH_SCHED_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                    bit_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else
`endif
                if (patch_ready) begin
                    if (bit_q != BIT_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else begin
                        bit_d = '0;
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (row_q != ROW_LAST) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                row_d   = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign patch_valid = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign first_bit   = (state_q == RUN) && (bit_q == '0);
    assign last_bit    = (state_q == RUN) && (bit_q == BIT_LAST);
    assign in_advance  = patch_valid && patch_ready;
    assign out_row     = row_q;
    assign out_col     = col_q;

    // Origin may go negative by up to PAD; the selector treats it as signed.
    assign base_h = BW'(row_q) * BW'(STRIDE) - BW'(PAD);
    assign base_w = BW'(col_q) * BW'(STRIDE) - BW'(PAD);

    stoch_signed_dyn_patch #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .CHANNELS (CHANNELS),
        .PATCH_W  (PATCH_W),
        .PATCH_H  (PATCH_H),
        .BW       (BW),
        .DEFAULT  (DEFAULT)
    ) u_patch (
        .base_h  (base_h),
        .base_w  (base_w),
        .in_p    (in_p),
        .in_m    (in_m),
        .patch_p (patch_p),
        .patch_m (patch_m)
    );

endmodule

// File: tb/tb_stoch_patch_scheduler.sv
// tb/tb_stoch_patch_scheduler.sv - directed bench for stoch_patch_scheduler (two configurations)
module tb_stoch_patch_scheduler;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    // A: 4x4, 1 ch, 3x3, stride 1, pad 1, 4 bits -> 4x4 windows
    logic                   start_a, ready_a;
    logic [3:0][3:0][0:0]   in_pa, in_ma;
    logic [0:0][2:0][2:0]   patch_p_a, patch_m_a;
    logic                   valid_a, first_a, last_a, adv_a, busy_a, done_a;
    logic [1:0]             row_a, col_a;

    // B: 5x5, 2 ch, 3x3, stride 2, pad 0, 2 bits -> 2x2 windows
    logic                   start_b, ready_b;
    logic [4:0][4:0][1:0]   in_pb, in_mb;
    logic [1:0][2:0][2:0]   patch_p_b, patch_m_b;
    logic                   valid_b, first_b, last_b, adv_b, busy_b, done_b;
    logic [0:0]             row_b, col_b;

`ifdef STOCH_PATCH_SCHED_ABORT_EN
    logic abort_a, abort_b;
`endif

    stoch_patch_scheduler #(
        .WIDTH(4), .HEIGHT(4), .CHANNELS(1), .PATCH_W(3), .PATCH_H(3),
        .STRIDE(1), .PAD(1), .BITS(4), .DEFAULT(1'b0)
    ) dut_a (
        .CLK(CLK), .nRST(nRST), .start(start_a),
`ifdef STOCH_PATCH_SCHED_ABORT_EN
        .abort(abort_a),
`endif
        .in_p(in_pa), .in_m(in_ma), .patch_p(patch_p_a), .patch_m(patch_m_a),
        .patch_valid(valid_a), .patch_ready(ready_a), .out_row(row_a), .out_col(col_a),
        .first_bit(first_a), .last_bit(last_a), .in_advance(adv_a), .busy(busy_a), .done(done_a)
    );

    stoch_patch_scheduler #(
        .WIDTH(5), .HEIGHT(5), .CHANNELS(2), .PATCH_W(3), .PATCH_H(3),
        .STRIDE(2), .PAD(0), .BITS(2), .DEFAULT(1'b0)
    ) dut_b (
        .CLK(CLK), .nRST(nRST), .start(start_b),
`ifdef STOCH_PATCH_SCHED_ABORT_EN
        .abort(abort_b),
`endif
        .in_p(in_pb), .in_m(in_mb), .patch_p(patch_p_b), .patch_m(patch_m_b),
        .patch_valid(valid_b), .patch_ready(ready_b), .out_row(row_b), .out_col(col_b),
        .first_bit(first_b), .last_bit(last_b), .in_advance(adv_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int          row;
        int          col;
        logic [15:0] ip;
        logic [15:0] im;
        logic [8:0]  ep;
        logic [8:0]  em;
    } avec_t;

    typedef struct {
        int          row;
        int          col;
        logic [17:0] ep;
        logic [17:0] em;
    } bvec_t;

    avec_t av[6];
    bvec_t bv[4];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
    endtask

    // Leaves the bench at the negedge after done, with the DUT back in IDLE.
    task automatic wait_done_a(input int limit);
        int n = 0;
        ready_a = 1'b1;
        while (!done_a && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("done_a_reached", 64'(done_a), 64'(1));
        @(negedge CLK);
    endtask

    initial begin
        // Window table for A; flat patch bit = r*3+k, flat map bit = h*4+w.
        av[0] = '{row: 0, col: 0, ip: 16'hFFFF, im: 16'h0000, ep: 9'h1B0, em: 9'h000};
        av[1] = '{row: 0, col: 3, ip: 16'hFFFF, im: 16'hFFFF, ep: 9'h0D8, em: 9'h0D8};
        av[2] = '{row: 1, col: 1, ip: 16'hFFFF, im: 16'h0001, ep: 9'h1FF, em: 9'h001};
        av[3] = '{row: 1, col: 1, ip: 16'h0200, im: 16'h0004, ep: 9'h080, em: 9'h004};
        av[4] = '{row: 2, col: 3, ip: 16'hFFFF, im: 16'h0800, ep: 9'h0DB, em: 9'h010};
        av[5] = '{row: 3, col: 3, ip: 16'hFFFF, im: 16'h8000, ep: 9'h01B, em: 9'h010};
        // B: p has ch0@(0,2) and ch1@(2,2); m has ch0@(4,4). Patch flat bit = c*9+r*3+k.
        bv[0] = '{row: 0, col: 0, ep: 18'h20004, em: 18'h00000};
        bv[1] = '{row: 0, col: 1, ep: 18'h08001, em: 18'h00000};
        bv[2] = '{row: 1, col: 0, ep: 18'h00800, em: 18'h00000};
        bv[3] = '{row: 1, col: 1, ep: 18'h00200, em: 18'h00100};

        nRST = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; in_pa = '0; in_ma = '0;
        start_b = 1'b0; ready_b = 1'b0; in_pb = '0; in_mb = '0;
`ifdef STOCH_PATCH_SCHED_ABORT_EN
        abort_a = 1'b0; abort_b = 1'b0;
`endif
        @(negedge CLK);
        chk("rst_valid_a", 64'(valid_a), 64'(0));
        chk("rst_busy_a",  64'(busy_a),  64'(0));
        chk("rst_done_a",  64'(done_a),  64'(0));
        chk("rst_row_a",   64'(row_a),   64'(0));
        chk("rst_col_a",   64'(col_a),   64'(0));
        chk("rst_first_a", 64'(first_a), 64'(0));
        chk("rst_valid_b", 64'(valid_b), 64'(0));
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_valid_a", 64'(valid_a), 64'(0));

        // Full sweep with ready held high.
        ready_a = 1'b1;
        pulse_start_a();
        for (int b = 0; b < 64; b++) begin
            chk("t1_valid", 64'(valid_a), 64'(1));
            chk("t1_busy",  64'(busy_a),  64'(1));
            chk("t1_row",   64'(row_a),   64'(b / 16));
            chk("t1_col",   64'(col_a),   64'((b / 4) % 4));
            chk("t1_first", 64'(first_a), 64'(b % 4 == 0));
            chk("t1_last",  64'(last_a),  64'(b % 4 == 3));
            chk("t1_adv",   64'(adv_a),   64'(1));
            chk("t1_done",  64'(done_a),  64'(0));
            @(negedge CLK);
        end
        chk("t1_done_pulse", 64'(done_a),  64'(1));
        chk("t1_busy_drop",  64'(busy_a),  64'(0));
        chk("t1_valid_drop", 64'(valid_a), 64'(0));
        chk("t1_row_end",    64'(row_a),   64'(0));
        chk("t1_col_end",    64'(col_a),   64'(0));
        @(negedge CLK);
        chk("t1_done_once",  64'(done_a),  64'(0));

        // Patch content at selected windows, stepping with ready pulses.
        ready_a = 1'b0;
        pulse_start_a();
        begin
            int cur = 0;
            for (int i = 0; i < 6; i++) begin
                while (cur < (av[i].row * 4 + av[i].col) * 4) begin
                    ready_a = 1'b1;
                    @(negedge CLK);
                    cur++;
                end
                ready_a = 1'b0;
                in_pa = av[i].ip;
                in_ma = av[i].im;
                #1;
                chk("t2_row",     64'(row_a),     64'(av[i].row));
                chk("t2_col",     64'(col_a),     64'(av[i].col));
                chk("t2_first",   64'(first_a),   64'(1));
                chk("t2_adv_off", 64'(adv_a),     64'(0));
                chk("t2_patch_p", 64'(patch_p_a), 64'(av[i].ep));
                chk("t2_patch_m", 64'(patch_m_a), 64'(av[i].em));
            end
        end
        wait_done_a(100);

        // Ready pattern 1,0,0,1: counters step only on accepted beats.
        pulse_start_a();
        begin
            int acc = 0;
            int adv = 0;
            for (int cyc = 0; cyc < 400 && acc < 64; cyc++) begin
                ready_a = (cyc % 4 == 0) || (cyc % 4 == 3);
                #1;
                chk("t3_valid", 64'(valid_a), 64'(1));
                chk("t3_row",   64'(row_a),   64'(acc / 16));
                chk("t3_col",   64'(col_a),   64'((acc / 4) % 4));
                chk("t3_first", 64'(first_a), 64'(acc % 4 == 0));
                chk("t3_adv",   64'(adv_a),   64'(ready_a));
                if (adv_a) adv++;
                @(negedge CLK);
                if (ready_a) acc++;
            end
            chk("t3_accepted", 64'(acc), 64'(64));
            chk("t3_adv_cnt",  64'(adv), 64'(64));
            chk("t3_done",     64'(done_a), 64'(1));
        end
        ready_a = 1'b0;
        @(negedge CLK);

        // Stride 2 / no padding on the 5x5 two-channel map.
        in_pb = '0;
        in_pb[0][2][0] = 1'b1;
        in_pb[2][2][1] = 1'b1;
        in_mb = '0;
        in_mb[4][4][0] = 1'b1;
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge CLK);
        start_b = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 2; b++) begin
                chk("t4_row",     64'(row_b),     64'(bv[w].row));
                chk("t4_col",     64'(col_b),     64'(bv[w].col));
                chk("t4_first",   64'(first_b),   64'(b == 0));
                chk("t4_last",    64'(last_b),    64'(b == 1));
                chk("t4_patch_p", 64'(patch_p_b), 64'(bv[w].ep));
                chk("t4_patch_m", 64'(patch_m_b), 64'(bv[w].em));
                @(negedge CLK);
            end
        end
        chk("t4_done", 64'(done_b), 64'(1));
        chk("t4_busy", 64'(busy_b), 64'(0));

        // Start ignored during RUN, then async reset at (1,2) bit 2.
        ready_a = 1'b1;
        pulse_start_a();
        for (int b = 0; b < 26; b++) begin
            start_a = (b == 5);
            @(negedge CLK);
        end
        start_a = 1'b0;
        chk("t5_row_pre",   64'(row_a),   64'(1));
        chk("t5_col_pre",   64'(col_a),   64'(2));
        chk("t5_first_pre", 64'(first_a), 64'(0));
        chk("t5_last_pre",  64'(last_a),  64'(0));
        #2;
        nRST = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(valid_a), 64'(0));
        chk("t5_rst_busy",  64'(busy_a),  64'(0));
        chk("t5_rst_row",   64'(row_a),   64'(0));
        chk("t5_rst_col",   64'(col_a),   64'(0));
        chk("t5_rst_last",  64'(last_a),  64'(0));
        chk("t5_rst_done",  64'(done_a),  64'(0));
        @(negedge CLK);
        nRST = 1'b1;
        pulse_start_a();
        chk("t5_re_valid", 64'(valid_a), 64'(1));
        chk("t5_re_row",   64'(row_a),   64'(0));
        chk("t5_re_col",   64'(col_a),   64'(0));
        chk("t5_re_first", 64'(first_a), 64'(1));
        @(negedge CLK);
        chk("t5_re_bit1",  64'(first_a), 64'(0));
        wait_done_a(100);

`ifdef STOCH_PATCH_SCHED_ABORT_EN
        // Abort wins over an accepted beat at beat 10.
        ready_a = 1'b1;
        pulse_start_a();
        for (int b = 0; b < 10; b++) @(negedge CLK);
        chk("t6_col_pre", 64'(col_a), 64'(2));
        abort_a = 1'b1;
        @(negedge CLK);
        abort_a = 1'b0;
        chk("t6_valid", 64'(valid_a), 64'(0));
        chk("t6_busy",  64'(busy_a),  64'(0));
        chk("t6_done",  64'(done_a),  64'(0));
        chk("t6_row",   64'(row_a),   64'(0));
        chk("t6_col",   64'(col_a),   64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_no_done", 64'(done_a), 64'(0));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
